// File: rtl/sound_pkg.sv
// Shared encodings for the sound scheduler: FSM states, event sources
// and the goal melody table.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_PLAY,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_HIT,
        SRC_WALL,
        SRC_GOAL
    } src_e;

    localparam int MEL_LEN = 3;

    // Pending flags are packed {goal, wall, hit}.
    function automatic src_e arb_pick(input logic [2:0] flags);
        src_e s;
        s = SRC_NONE;
        if (flags[2]) begin
            s = SRC_GOAL;
        end else if (flags[1]) begin
            s = SRC_WALL;
        end else if (flags[0]) begin
            s = SRC_HIT;
        end
        return s;
    endfunction

    function automatic logic [2:0] src_mask(input src_e s);
        logic [2:0] m;
        m = 3'b000;
        case (s)
            SRC_HIT:  m = 3'b001;
            SRC_WALL: m = 3'b010;
            SRC_GOAL: m = 3'b100;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic src_e melody_note(input logic [1:0] idx);
        src_e s;
        case (idx)
            2'd0:    s = SRC_GOAL;
            2'd1:    s = SRC_HIT;
            2'd2:    s = SRC_WALL;
            default: s = SRC_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sound_scheduler.sv
// Serialises game sound events onto one tone generator: pending flags,
// fixed-priority arbitration, tone/gap pacing and the goal melody.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int TONE_LEN = 16777216,
    parameter int GAP_LEN  = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic hit_req,
    input  logic wall_req,
    input  logic goal_req,
    input  logic mute,
    output logic hit,
    output logic wall,
    output logic goal,
    output logic busy,
    output logic dropped
);

    localparam int MAX_LEN = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    // Counter holds remaining cycles minus one; ISSUE already spent one.
    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(TONE_LEN - 2);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [1:0]       MEL_LAST  = 2'(MEL_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       flags_q, flags_d;
    logic [1:0]       mel_q, mel_d;
    logic             drop_q, drop_d;
    logic             hit_q, hit_d;
    logic             wall_q, wall_d;
    logic             goal_q, goal_d;
    logic             busy_q, busy_d;
    logic             dropped_q, dropped_d;

    logic [2:0] req;
    logic [2:0] grant;
    src_e       arb_src;
    src_e       issue_src;
    logic       arb_take;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mel_d     = mel_q;
        issue_src = SRC_NONE;
        arb_take  = 1'b0;
        req       = {goal_req, wall_req, hit_req};
        arb_src   = arb_pick(flags_q);

        unique case (state_q)
            ST_IDLE: begin
                if (|flags_q) begin
                    state_d  = ST_ISSUE;
                    arb_take = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_PLAY;
                cnt_d   = PLAY_LOAD;
            end
            ST_PLAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (mel_q != 2'd0) begin
                    state_d   = ST_ISSUE;
                    cnt_d     = '0;
                    issue_src = melody_note(mel_q);
                    mel_d     = (mel_q == MEL_LAST) ? 2'd0 : mel_q + 2'd1;
                end else if (|flags_q) begin
                    state_d  = ST_ISSUE;
                    cnt_d    = '0;
                    arb_take = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A granted goal starts the melody; its later notes bypass the flags.
        if (arb_take) begin
            issue_src = arb_src;
            if (arb_src == SRC_GOAL) begin
                mel_d = 2'd1;
            end
        end

        grant   = arb_take ? src_mask(arb_src) : 3'b000;
        flags_d = (flags_q & ~grant) | req;
        drop_d  = |(req & flags_q & ~grant);

        if (mute) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            mel_d     = 2'd0;
            flags_d   = 3'b000;
            drop_d    = 1'b0;
            issue_src = SRC_NONE;
        end

        hit_d     = (issue_src == SRC_HIT);
        wall_d    = (issue_src == SRC_WALL);
        goal_d    = (issue_src == SRC_GOAL);
        busy_d    = (state_d != ST_IDLE);
        dropped_d = drop_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            flags_q   <= 3'b000;
            mel_q     <= 2'd0;
            drop_q    <= 1'b0;
            hit_q     <= 1'b0;
            wall_q    <= 1'b0;
            goal_q    <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flags_q   <= flags_d;
            mel_q     <= mel_d;
            drop_q    <= drop_d;
            hit_q     <= hit_d;
            wall_q    <= wall_d;
            goal_q    <= goal_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign hit     = hit_q;
    assign wall    = wall_q;
    assign goal    = goal_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler with TONE_LEN=8, GAP_LEN=4:
// stimulus queues expected output events, a monitor pops and compares.
module tb_sound_scheduler;

    typedef enum int {
        EV_GOAL,
        EV_WALL,
        EV_HIT,
        EV_DROP,
        EV_BRISE,
        EV_BFALL
    } ev_e;

    typedef struct {
        int  cyc;
        ev_e kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hit_req = 1'b0;
    logic wall_req = 1'b0;
    logic goal_req = 1'b0;
    logic mute = 1'b0;
    logic hit, wall, goal, busy, dropped;

    int   now = -100;
    int   vectors = 0;
    int   errors = 0;
    logic busy_prev = 1'b0;
    logic end_chk = 1'b0;
    exp_t exp_q[$];

    sound_scheduler #(
        .TONE_LEN(8),
        .GAP_LEN (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .hit_req (hit_req),
        .wall_req(wall_req),
        .goal_req(goal_req),
        .mute    (mute),
        .hit     (hit),
        .wall    (wall),
        .goal    (goal),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic check_ev(input ev_e k);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at cycle %0d, want nothing",
                     k.name(), now);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != now) begin
                errors++;
                $display("FAIL event: got %s at cycle %0d, want %s at %0d",
                         k.name(), now, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Monitor: every output event is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if ({hit, wall, goal, busy, dropped} != 5'b0) begin
                errors++;
                $display("FAIL reset_outs: got %b want 00000",
                         {hit, wall, goal, busy, dropped});
            end
        end
        if (hit || wall || goal) begin
            vectors++;
            if (int'(hit) + int'(wall) + int'(goal) > 1) begin
                errors++;
                $display("FAIL onehot: cycle %0d got hwg=%b%b%b want one",
                         now, hit, wall, goal);
            end
        end
        if (goal)
            check_ev(EV_GOAL);
        if (wall)
            check_ev(EV_WALL);
        if (hit)
            check_ev(EV_HIT);
        if (dropped)
            check_ev(EV_DROP);
        if (busy && !busy_prev)
            check_ev(EV_BRISE);
        if (!busy && busy_prev)
            check_ev(EV_BFALL);
        busy_prev = busy;
        if (end_chk) begin
            vectors++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_events: got %0d left, want 0 (next %s@%0d)",
                         exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
                exp_q.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic at(input int k);
        while (now < k)
            tick();
    endtask

    task automatic ex(input int c, input ev_e k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic start_scn();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        now = 0;
    endtask

    task automatic finish_scn();
        at(75);
        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;
    endtask

    initial begin
        // Single hit from idle.
        start_scn();
        ex(12, EV_HIT);
        ex(12, EV_BRISE);
        ex(24, EV_BFALL);
        at(10); hit_req = 1'b1;
        at(11); hit_req = 1'b0;
        finish_scn();

        // Simultaneous wall and hit: wall wins.
        start_scn();
        ex(12, EV_WALL);
        ex(12, EV_BRISE);
        ex(24, EV_HIT);
        ex(36, EV_BFALL);
        at(10); wall_req = 1'b1; hit_req = 1'b1;
        at(11); wall_req = 1'b0; hit_req = 1'b0;
        finish_scn();

        // Goal melody, then the hit that arrived during it.
        start_scn();
        ex(12, EV_GOAL);
        ex(12, EV_BRISE);
        ex(24, EV_HIT);
        ex(36, EV_WALL);
        ex(48, EV_HIT);
        ex(60, EV_BFALL);
        at(10); goal_req = 1'b1;
        at(11); goal_req = 1'b0;
        at(15); hit_req = 1'b1;
        at(16); hit_req = 1'b0;
        finish_scn();

        // Repeated hits: 11 coincides with grant, 13 is dropped.
        start_scn();
        ex(12, EV_HIT);
        ex(12, EV_BRISE);
        ex(15, EV_DROP);
        ex(24, EV_HIT);
        ex(36, EV_BFALL);
        at(10); hit_req = 1'b1;
        at(12); hit_req = 1'b0;
        at(13); hit_req = 1'b1;
        at(14); hit_req = 1'b0;
        finish_scn();

        // Mute during a melody; wall request while muted is ignored.
        start_scn();
        ex(12, EV_GOAL);
        ex(12, EV_BRISE);
        ex(17, EV_BFALL);
        at(10); goal_req = 1'b1;
        at(11); goal_req = 1'b0;
        at(16); mute = 1'b1;
        at(18); wall_req = 1'b1;
        at(19); wall_req = 1'b0;
        at(21); mute = 1'b0;
        finish_scn();

        // Reset mid-tone with a hit pending: nothing follows.
        start_scn();
        ex(12, EV_WALL);
        ex(12, EV_BRISE);
        ex(18, EV_BFALL);
        at(10); wall_req = 1'b1;
        at(11); wall_req = 1'b0;
        at(14); hit_req = 1'b1;
        at(15); hit_req = 1'b0;
        at(18); rst = 1'b1;
        at(19); rst = 1'b0;
        finish_scn();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 SHALL have parameter TONE_LEN, default 16777216, meaning cycles one tone occupies the tone generator (2^24, its tone window).
REQ-002 SHALL have parameter GAP_LEN, default 2500000, meaning silent cycles between consecutive tones (50 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports hit_req, wall_req, goal_req  input  1 each  single-cycle event requests from game logic.
REQ-006 SHALL have port mute  input  1  level; suppresses all sound activity.
REQ-007 SHALL have ports hit, wall, goal  output  1 each  single-cycle triggers to the tone generator.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port dropped  output  1  single-cycle pulse when a request is discarded.

Function
REQ-010 SHALL keep one pending flag per source; req sets it at the next edge.
REQ-011 SHALL discard a request whose flag is already set and not being granted that cycle, pulsing dropped the following cycle.
REQ-012 SHALL, when a request and a grant of the same source coincide, leave the flag set (new request kept, no drop).
REQ-013 SHALL arbitrate fixed priority goal > wall > hit among pending flags.
REQ-014 SHALL implement FSM states IDLE, ISSUE, PLAY, GAP.
REQ-015 IDLE: any flag set -> ISSUE next edge; winner latched, its flag cleared on the same edge.
REQ-016 ISSUE: exactly one cycle; the latched trigger output high; -> PLAY.
REQ-017 PLAY: TONE_LEN-1 cycles; -> GAP.
REQ-018 GAP: GAP_LEN cycles; then melody continuation, else ISSUE if any flag set, else IDLE.
REQ-019 SHALL play a granted goal as a 3-note melody: goal, hit, wall; notes 2-3 are issued without arbitration and occupy no pending flags.
REQ-020 SHALL leave requests arriving during a melody latched for service after note 3.
REQ-021 SHALL produce a trigger 2 cycles after a request cycle when IDLE with no flags set.
REQ-022 SHALL space consecutive trigger rising edges exactly TONE_LEN+GAP_LEN cycles apart.
REQ-023 SHALL never assert more than one trigger output in any cycle.
REQ-024 SHALL, while mute=1, ignore requests without dropped, clear all flags and the melody index, and go to IDLE at the next edge, asserting no triggers.
REQ-025 SHALL use one down-counter, width ceil(log2(max(TONE_LEN,GAP_LEN)))+1, reloaded on each state entry.
REQ-026 SHALL register all outputs.

Reset
REQ-027 SHALL on rst force IDLE, clear flags, counter, melody index; hit, wall, goal, busy, dropped all 0.
REQ-028 SHALL abandon any tone or melody in progress on reset mid-operation, with no trigger after rst deasserts until a new request.

Structure
REQ-029 SHALL take the state encoding, source encoding (NONE, HIT, WALL, GOAL) and melody table from shared package sound_pkg.
REQ-030 SHALL be a single module without sub-modules; the tone generator is instantiated beside it at the top level.

Verification (TONE_LEN=8, GAP_LEN=4)
REQ-031 hit_req at cycle 10 -> hit high only in cycle 12; busy 12..23; IDLE at cycle 24.
REQ-032 wall_req and hit_req both at cycle 10 -> wall at 12, hit at 24.
REQ-033 goal_req at 10, hit_req at 15 -> goal 12, hit 24, wall 36, hit 48; dropped never asserted.
REQ-034 hit_req at 10, 11, 13 -> hit at 12 and 24; dropped at 15 only (13 discarded; 11 granted).
REQ-035 mute high cycles 16-20 during a melody started at 12 -> no trigger after 12; busy 0 from 17; wall_req at 18 ignored.
REQ-036 rst pulse at cycle 18 during PLAY with hit pending -> all outputs 0; no trigger through cycle 60.
